// File: rtl/ip_pkg.sv
// Shared constants and FSM state type for the IPv4 transmit header generator.
package ip_pkg;

   localparam logic [3:0]  IP_VERSION     = 4'd4;
   localparam logic [3:0]  IP_IHL         = 4'd5;
   localparam int          IP_HDR_BYTES   = 20;
   localparam logic [2:0]  IP_FLAGS_DF    = 3'b010;
   localparam logic [15:0] IP_MAX_PAYLOAD = 16'd65515;

   typedef enum logic [1:0] {
      IDLE,
      SUM,
      FOLD,
      SEND
   } ip_state_t;

endpackage

// File: rtl/ip_csum_accum.sv
// 20-bit one's-complement accumulator with end-around-carry fold to a registered checksum.
module ip_csum_accum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        add,
   input  logic        fold,
   input  logic [15:0] word,
   output logic [15:0] cksum
);

   logic [19:0] acc_reg;
   logic [15:0] cksum_reg;
   logic [16:0] s1;
   logic [15:0] s2;

   // s1[16] set implies s1[15:0] is tiny, so the second fold cannot carry again.
   always_comb begin
      s1 = {1'b0, acc_reg[15:0]} + {13'd0, acc_reg[19:16]};
      s2 = s1[15:0] + {15'd0, s1[16]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg   <= '0;
         cksum_reg <= '0;
      end else begin
         if (clear) begin
            acc_reg <= '0;
         end else if (add) begin
            acc_reg <= acc_reg + {4'd0, word};
         end
         if (fold) begin
            cksum_reg <= ~s2;
         end
      end
   end

   assign cksum = cksum_reg;

endmodule

// File: rtl/ip_tx_header.sv
// IPv4 header generator: sums header words, folds the checksum, then streams 20 bytes.
// Define IP_TX_ID_AUTO_EN to source the identification field from an internal counter.
module ip_tx_header
   import ip_pkg::*;
#(
   parameter logic [7:0] DEF_TTL = 8'd64,
   parameter logic [7:0] DEF_TOS = 8'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] payload_len,
   input  logic [7:0]  protocol,
   input  logic [31:0] source_ip,
   input  logic [31:0] dest_ip,
   input  logic [15:0] identification,
   output logic        busy,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        done,
   output logic        err
);

   ip_state_t   state_reg, state_next;
   logic [3:0]  idx_reg, idx_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic [15:0] total_len_reg, id_reg;
   logic [7:0]  protocol_reg;
   logic [31:0] src_reg, dst_reg;
   logic        done_reg, err_reg;
   logic [16:0] total_len_full;
   logic        len_over, accept, acc_clear, acc_add, acc_fold, last_xfer;
   logic [15:0] sum_word, cksum, id_src;
   logic [7:0]  addr_bytes [0:7];
   logic [7:0]  hdr_bytes  [0:IP_HDR_BYTES-1];

   assign total_len_full = {1'b0, payload_len} + 17'(IP_HDR_BYTES);
   assign len_over       = total_len_full[16];

`ifdef IP_TX_ID_AUTO_EN
   logic [15:0] id_cnt_reg;
   logic        unused_id;

   // Advance on the final byte transfer so a start in the done cycle sees the new ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_cnt_reg <= '0;
      end else if (last_xfer) begin
         id_cnt_reg <= id_cnt_reg + 16'd1;
      end
   end

   assign id_src    = id_cnt_reg;
   assign unused_id = ^identification;
`else
   assign id_src = identification;
`endif

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      acc_clear  = 1'b0;
      acc_add    = 1'b0;
      acc_fold   = 1'b0;
      last_xfer  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !len_over) begin
               accept     = 1'b1;
               acc_clear  = 1'b1;
               idx_next   = '0;
               state_next = SUM;
            end
         end
         SUM: begin
            acc_add = 1'b1;
            if (idx_reg == 4'd9) begin
               state_next = FOLD;
            end else begin
               idx_next = idx_reg + 4'd1;
            end
         end
         FOLD: begin
            acc_fold   = 1'b1;
            cnt_next   = '0;
            state_next = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (cnt_reg == 5'(IP_HDR_BYTES - 1)) begin
                  last_xfer  = 1'b1;
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg + 5'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         cnt_reg       <= '0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         total_len_reg <= '0;
         id_reg        <= '0;
         protocol_reg  <= '0;
         src_reg       <= '0;
         dst_reg       <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         done_reg  <= last_xfer;
         err_reg   <= (state_reg == IDLE) && start && len_over;
         if (accept) begin
            total_len_reg <= total_len_full[15:0];
            id_reg        <= id_src;
            protocol_reg  <= protocol;
            src_reg       <= source_ip;
            dst_reg       <= dest_ip;
         end
      end
   end

   always_comb begin
      case (idx_reg)
         4'd0:    sum_word = {IP_VERSION, IP_IHL, DEF_TOS};
         4'd1:    sum_word = total_len_reg;
         4'd2:    sum_word = id_reg;
         4'd3:    sum_word = {IP_FLAGS_DF, 13'd0};
         4'd4:    sum_word = {DEF_TTL, protocol_reg};
         4'd5:    sum_word = src_reg[31:16];
         4'd6:    sum_word = src_reg[15:0];
         4'd7:    sum_word = dst_reg[31:16];
         4'd8:    sum_word = dst_reg[15:0];
         default: sum_word = 16'h0000;
      endcase
   end

   ip_csum_accum u_csum (
      .clk   (clk),
      .rst   (rst),
      .clear (acc_clear),
      .add   (acc_add),
      .fold  (acc_fold),
      .word  (sum_word),
      .cksum (cksum)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_addr
         assign addr_bytes[gi]     = src_reg[31-8*gi -: 8];
         assign addr_bytes[gi + 4] = dst_reg[31-8*gi -: 8];
      end
   endgenerate

   always_comb begin
      hdr_bytes[0]  = {IP_VERSION, IP_IHL};
      hdr_bytes[1]  = DEF_TOS;
      hdr_bytes[2]  = total_len_reg[15:8];
      hdr_bytes[3]  = total_len_reg[7:0];
      hdr_bytes[4]  = id_reg[15:8];
      hdr_bytes[5]  = id_reg[7:0];
      hdr_bytes[6]  = {IP_FLAGS_DF, 5'd0};
      hdr_bytes[7]  = 8'h00;
      hdr_bytes[8]  = DEF_TTL;
      hdr_bytes[9]  = protocol_reg;
      hdr_bytes[10] = cksum[15:8];
      hdr_bytes[11] = cksum[7:0];
      for (int i = 0; i < 8; i++) begin
         hdr_bytes[12 + i] = addr_bytes[i];
      end
   end

   assign busy      = (state_reg != IDLE);
   assign out_valid = (state_reg == SEND);
   assign out_last  = out_valid && (cnt_reg == 5'(IP_HDR_BYTES - 1));
   assign out_data  = out_valid ? hdr_bytes[cnt_reg] : 8'h00;
   assign done      = done_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_ip_tx_header.sv
// Self-checking bench for ip_tx_header: literal nominal headers, backpressure, length limits,
// reset abandonment, start-while-busy, plus a table of model-checked packets.
module tb_ip_tx_header;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] payload_len;
   logic [7:0]  protocol;
   logic [31:0] source_ip;
   logic [31:0] dest_ip;
   logic [15:0] identification;
   logic        busy;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   ip_tx_header dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .payload_len    (payload_len),
      .protocol       (protocol),
      .source_ip      (source_ip),
      .dest_ip        (dest_ip),
      .identification (identification),
      .busy           (busy),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .done           (done),
      .err            (err)
   );

   typedef struct {
      logic [15:0] len;
      logic [7:0]  proto;
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] id;
      bit          toggle;
      bit          exp_err;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   bit          stall_pend = 0;
   logic [7:0]  held_data;
   logic        held_last;
   logic [15:0] exp_auto_id = 16'd0;
   logic [7:0]  nom0 [20];
   logic [7:0]  nom1 [20];
   vec_t        tbl  [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Independent header model: build bytes, then sum/fold with a loop-until-no-carry.
   function automatic void push_model(input vec_t v, input logic [15:0] id);
      logic [7:0]  b [20];
      logic [15:0] tl;
      int unsigned s;
      tl = v.len + 16'd20;
      b = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
            8'd64, v.proto, 8'h00, 8'h00,
            v.src[31:24], v.src[23:16], v.src[15:8], v.src[7:0],
            v.dst[31:24], v.dst[23:16], v.dst[15:8], v.dst[7:0]};
      s = 0;
      for (int i = 0; i < 20; i += 2) s += {16'd0, b[i], b[i+1]};
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      b[10] = ~s[15:8];
      b[11] = ~s[7:0];
      for (int i = 0; i < 20; i++) exp_q.push_back(b[i]);
   endfunction

   function automatic void push_lit(input logic [7:0] b [20]);
      for (int i = 0; i < 20; i++) exp_q.push_back(b[i]);
   endfunction

   // Byte monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
   always @(negedge clk) begin
      if (rst) begin
         stall_pend = 0;
      end else if (out_valid) begin
         if (stall_pend) begin
            check("hold_data", out_data, held_data);
            check("hold_last", out_last, held_last);
         end
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_byte actual=%h required=none", out_data);
            end else begin
               logic exp_last;
               logic [7:0] exp_b;
               exp_last = (exp_q.size() == 1);
               exp_b = exp_q.pop_front();
               check("byte", out_data, exp_b);
               check("last", out_last, exp_last);
               $display("byte %h last=%0b", out_data, out_last);
            end
            stall_pend = 0;
         end else begin
            stall_pend = 1;
            held_data  = out_data;
            held_last  = out_last;
         end
      end else begin
         if (stall_pend) check("valid_hold", out_valid, 1);
         stall_pend = 0;
      end
   end

   // Starts a packet in the current cycle and waits (bounded) for done.
   task automatic run_pkt(input vec_t v, input bit poke);
      int cyc;
      int first_valid;
      bit got_done;
      payload_len    = v.len;
      protocol       = v.proto;
      source_ip      = v.src;
      dest_ip        = v.dst;
      identification = v.id;
      out_ready      = 1'b1;
      start          = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      if (v.exp_err) begin
         check("err_pulse", err, 1);
         check("err_busy", busy, 0);
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) check("err_one_cycle", err, 0);
            check("err_no_valid", out_valid, 0);
            check("err_busy_low", busy, 0);
         end
         $display("pkt len=%0d rejected", v.len);
         return;
      end
      check("busy_rise", busy, 1);
      check("no_err", err, 0);
      first_valid = 0;
      got_done    = 0;
      while (!got_done && cyc < 200) begin
         if (v.toggle) out_ready = cyc[0];
         if (poke && cyc == 3) begin
            start       = 1'b1;
            dest_ip     = ~v.dst;
            payload_len = 16'hFFFF;
         end
         @(posedge clk); #1;
         cyc++;
         start       = 1'b0;
         dest_ip     = v.dst;
         payload_len = v.len;
         if (poke && cyc == 4) begin
            check("poke_no_err", err, 0);
            check("poke_busy", busy, 1);
         end
         if (out_valid && first_valid == 0) first_valid = cyc;
         if (done) got_done = 1;
      end
      check("done_seen", got_done, 1);
      if (!v.toggle) begin
         check("first_valid_cycle", first_valid, 12);
         check("done_cycle", cyc, 32);
      end
      check("busy_at_done", busy, 0);
      check("valid_drop", out_valid, 0);
      check("queue_drained", exp_q.size(), 0);
      out_ready = 1'b1;
      if (got_done) exp_auto_id++;
      $display("pkt len=%0d proto=%h done_cycle=%0d", v.len, v.proto, cyc);
   endtask

   initial begin
      vec_t nv;
      int   cyc;
      logic [15:0] id_exp;

      nom0 = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
      nom1 = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB8, 8'h60, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
      tbl[0] = '{16'd65515, 8'h11, 32'hC0A80001, 32'hC0A800C7, 16'h0000, 1'b0, 1'b0};
      tbl[1] = '{16'd65516, 8'h11, 32'hC0A80001, 32'hC0A800C7, 16'h0000, 1'b0, 1'b1};
      tbl[2] = '{16'd0,     8'h06, 32'h0A000001, 32'hFFFFFFFF, 16'h1234, 1'b0, 1'b0};
      tbl[3] = '{16'd1472,  8'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 1'b1, 1'b0};
      tbl[4] = '{16'hFFFF,  8'h11, 32'h01020304, 32'h05060708, 16'h0001, 1'b0, 1'b1};
      tbl[5] = '{16'd8,     8'h01, 32'hAC100A01, 32'h08080808, 16'hABCD, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      payload_len = '0; protocol = '0; source_ip = '0; dest_ip = '0; identification = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_data", out_data, 8'h00);
      rst = 1'b0;
      @(posedge clk); #1;

      // Nominal packet, then a second one started in the done cycle (ID 1).
      nv = '{16'd95, 8'h11, 32'hC0A80001, 32'hC0A800C7, 16'h0000, 1'b0, 1'b0};
      exp_auto_id = 0;
      push_lit(nom0);
      run_pkt(nv, 1'b0);
      nv.id = 16'h0001;
      push_lit(nom1);
      run_pkt(nv, 1'b0);
      check("done_one_cycle_pre", done, 1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);

      // Reset while byte 7 is presented: everything drops, no done.
      nv.id = 16'h0000;
      push_lit(nom0);
      payload_len = nv.len; protocol = nv.proto; source_ip = nv.src;
      dest_ip = nv.dst; identification = nv.id; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 19) begin
         @(posedge clk); #1;
         cyc++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      exp_auto_id = 0;
      check("midrst_valid", out_valid, 0);
      check("midrst_last", out_last, 0);
      check("midrst_data", out_data, 8'h00);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_err", err, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("midrst_no_done", done, 0);
      end
      $display("reset mid-send applied");

      // Restart after reset under backpressure: must match the nominal bytes exactly.
      nv.toggle = 1'b1;
      push_lit(nom0);
      run_pkt(nv, 1'b0);

      // Start while busy during SUM is ignored.
      nv = '{16'd95, 8'h11, 32'hC0A80001, 32'hC0A800C7, 16'h0002, 1'b0, 1'b0};
`ifdef IP_TX_ID_AUTO_EN
      push_model(nv, exp_auto_id);
`else
      push_model(nv, nv.id);
`endif
      run_pkt(nv, 1'b1);

      for (int i = 0; i < 6; i++) begin
`ifdef IP_TX_ID_AUTO_EN
         id_exp = exp_auto_id;
`else
         id_exp = tbl[i].id;
`endif
         if (!tbl[i].exp_err) push_model(tbl[i], id_exp);
         run_pkt(tbl[i], 1'b0);
         @(posedge clk); #1;
      end

      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
